// File: rtl/camera_stream_gen.sv
// ---------------------------------------------------------------------------
// camera_stream_gen
//
// Emulates a parallel-bus camera sensor producing RGB565 frames (two bytes
// per pixel) with HREF/VSYNC framing and a PCLK running at CLK/2.
//
// All framing state advances only on "ticks": the CLK edges on which PCLK
// falls. Every visible output therefore changes while PCLK drops and stays
// stable across the following PCLK rising edge, where a receiver samples it.
//
// Parameters
//   H_ACTIVE      pixels per line
//   V_ACTIVE      lines per frame
//   VSYNC_TICKS   PCLK periods with VSYNC high
//   VBP_TICKS     PCLK periods from VSYNC fall to the first HREF rise
//   HBLANK_TICKS  PCLK periods with HREF low between lines
//   VFP_TICKS     PCLK periods after the last line before the frame ends
//
// Ports
//   CLK          in   sole clock, rising edge
//   RESET        in   asynchronous, active-high reset
//   ENABLE       in   level; high requests continuous frame generation
//   PATTERN[1:0] in   0 colour bars, 1 solid, 2 checkerboard, 3 column ramp
//   SOLID_COLOR  in   RGB332 colour used by the solid pattern
//   PCLK         out  emulated pixel clock, CLK/2
//   HREF         out  high while line bytes are valid
//   VSYNC        out  high during the frame sync interval
//   DATA[7:0]    out  camera byte (RGB565 high byte first), 00 when HREF low
//   BUSY         out  high from frame start through FRAME_DONE
//   FRAME_DONE   out  one-CLK pulse at the end of the vertical front porch
// ---------------------------------------------------------------------------
module camera_stream_gen #(
  parameter int H_ACTIVE     = 176,
  parameter int V_ACTIVE     = 144,
  parameter int VSYNC_TICKS  = 8,
  parameter int VBP_TICKS    = 16,
  parameter int HBLANK_TICKS = 32,
  parameter int VFP_TICKS    = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [1:0] PATTERN,
  input  logic [7:0] SOLID_COLOR,
  output logic       PCLK,
  output logic       HREF,
  output logic       VSYNC,
  output logic [7:0] DATA,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  // Tick counter must hold the longest of the blanking intervals.
  localparam int T01  = (VSYNC_TICKS > VBP_TICKS) ? VSYNC_TICKS : VBP_TICKS;
  localparam int T23  = (HBLANK_TICKS > VFP_TICKS) ? HBLANK_TICKS : VFP_TICKS;
  localparam int TMAX = (T01 > T23) ? T01 : T23;
  localparam int TW   = $clog2(TMAX + 1);

  // Line counter is at least 5 bits so the checkerboard can read line[4].
  localparam int LW0 = $clog2(V_ACTIVE);
  localparam int LW  = (LW0 < 5) ? 5 : LW0;

  // Pixel index is at least 8 bits so the ramp can read x[7:0];
  // the byte counter carries one extra LSB selecting byte0/byte1.
  localparam int XW0 = $clog2(H_ACTIVE);
  localparam int XW  = (XW0 < 8) ? 8 : XW0;
  localparam int BW  = XW + 1;

  localparam int BAR_W = ((H_ACTIVE / 8) < 1) ? 1 : (H_ACTIVE / 8);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } state_t;

  // RGB332 -> RGB565 by replicating the most significant bits of each field.
  function automatic logic [15:0] rgb332_to_565(input logic [7:0] c);
    return {c[7:5], c[7:6], c[4:2], c[4:2], c[1:0], c[1:0], c[1]};
  endfunction

  // Colour of each of the eight vertical bars, left to right.
  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hFF;  // white
      3'd1:    c = 8'hFC;  // yellow
      3'd2:    c = 8'h0B;  // light blue
      3'd3:    c = 8'h1C;  // green
      3'd4:    c = 8'hE3;  // purple
      3'd5:    c = 8'hE0;  // red
      3'd6:    c = 8'h03;  // blue
      default: c = 8'h00;  // black
    endcase
    return c;
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [LW-1:0]   line_q, line_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [1:0]      pat_q, pat_d;
  logic [7:0]      solid_q, solid_d;
  logic            pclk_q, pclk_d;
  logic            href_q, href_d;
  logic            vsync_q, vsync_d;
  logic [7:0]      data_q, data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tick_s;
  logic [XW-1:0]   x_s;
  logic [XW-1:0]   bar_s;
  logic [7:0]      col_s;
  logic [15:0]     rgb_s;
  logic [7:0]      byte_s;

  // A tick is the CLK edge on which PCLK goes from 1 to 0.
  assign tick_s = pclk_q;

  // Next-state logic: frame sequencing, counters and per-frame latches.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    line_d     = line_q;
    byte_cnt_d = byte_cnt_q;
    pat_d      = pat_q;
    solid_d    = solid_q;
    done_d     = 1'b0;
    pclk_d     = ~pclk_q;

    if (tick_s) begin
      case (state_q)
        ST_IDLE: begin
          if (ENABLE) begin
            state_d = ST_VSYNC;
            tick_d  = {TW{1'b0}};
            pat_d   = PATTERN;
            solid_d = SOLID_COLOR;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_VSYNC: begin
          if (tick_q == TW'(VSYNC_TICKS - 1)) begin
            state_d = ST_VBP;
            tick_d  = {TW{1'b0}};
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_VBP: begin
          if (tick_q == TW'(VBP_TICKS - 1)) begin
            state_d    = ST_ACTIVE;
            tick_d     = {TW{1'b0}};
            line_d     = {LW{1'b0}};
            byte_cnt_d = {BW{1'b0}};
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_ACTIVE: begin
          if (byte_cnt_q == BW'(2 * H_ACTIVE - 1)) begin
            byte_cnt_d = {BW{1'b0}};
            tick_d     = {TW{1'b0}};
            // The last line goes straight into the front porch.
            if (line_q == LW'(V_ACTIVE - 1)) begin
              state_d = ST_VFP;
            end else begin
              state_d = ST_HBLANK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end

        ST_HBLANK: begin
          if (tick_q == TW'(HBLANK_TICKS - 1)) begin
            state_d    = ST_ACTIVE;
            tick_d     = {TW{1'b0}};
            line_d     = line_q + LW'(1);
            byte_cnt_d = {BW{1'b0}};
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        ST_VFP: begin
          if (tick_q == TW'(VFP_TICKS - 1)) begin
            done_d = 1'b1;
            tick_d = {TW{1'b0}};
            line_d = {LW{1'b0}};
            // Back-to-back frames re-latch the pattern inputs here.
            if (ENABLE) begin
              state_d = ST_VSYNC;
              pat_d   = PATTERN;
              solid_d = SOLID_COLOR;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end

        default: begin
          state_d    = ST_IDLE;
          tick_d     = {TW{1'b0}};
          line_d     = {LW{1'b0}};
          byte_cnt_d = {BW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Pixel colour for the byte about to be driven, from the latched pattern.
  always_comb begin
    x_s   = byte_cnt_d[BW-1:1];
    bar_s = x_s / XW'(BAR_W);
    col_s = 8'h00;

    case (pat_d)
      2'd0: begin
        // Any remainder pixels when H_ACTIVE is not a multiple of 8 stay black.
        if (bar_s > XW'(7)) begin
          col_s = bar_color(3'd7);
        end else begin
          col_s = bar_color(bar_s[2:0]);
        end
      end
      2'd1:    col_s = solid_d;
      2'd2:    col_s = (x_s[4] ^ line_d[4]) ? 8'h00 : 8'hFF;
      2'd3:    col_s = x_s[7:0];
      default: col_s = 8'h00;
    endcase

    rgb_s = rgb332_to_565(col_s);
    if (byte_cnt_d[0]) begin
      byte_s = rgb_s[7:0];
    end else begin
      byte_s = rgb_s[15:8];
    end
  end

  // Output next values: decoded from the state being entered so that the
  // registered outputs line up with the state for the whole tick period.
  always_comb begin
    href_d  = href_q;
    vsync_d = vsync_q;
    data_d  = data_q;
    busy_d  = busy_q;

    if (tick_s) begin
      vsync_d = (state_d == ST_VSYNC);
      href_d  = (state_d == ST_ACTIVE);
      // BUSY stays high through the FRAME_DONE pulse even when going idle.
      busy_d  = (state_d != ST_IDLE) || done_d;
      if (state_d == ST_ACTIVE) begin
        data_d = byte_s;
      end else begin
        data_d = 8'h00;
      end
    end else begin
      busy_d = busy_q;
    end
  end

  // State and output registers; RESET aborts any frame immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      tick_q     <= {TW{1'b0}};
      line_q     <= {LW{1'b0}};
      byte_cnt_q <= {BW{1'b0}};
      pat_q      <= 2'b00;
      solid_q    <= 8'h00;
      pclk_q     <= 1'b0;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      line_q     <= line_d;
      byte_cnt_q <= byte_cnt_d;
      pat_q      <= pat_d;
      solid_q    <= solid_d;
      pclk_q     <= pclk_d;
      href_q     <= href_d;
      vsync_q    <= vsync_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign PCLK       = pclk_q;
  assign HREF       = href_q;
  assign VSYNC      = vsync_q;
  assign DATA       = data_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: doc/camera_stream_gen.md
CAMERA_STREAM_GEN -- requirements
Module: camera_stream_gen

Interface
REQ-001 Parameter H_ACTIVE, default 176, pixels per line.
REQ-002 Parameter V_ACTIVE, default 144, lines per frame.
REQ-003 Parameter VSYNC_TICKS, default 8, PCLK periods with VSYNC high.
REQ-004 Parameter VBP_TICKS, default 16, PCLK periods from VSYNC fall to first HREF rise.
REQ-005 Parameter HBLANK_TICKS, default 32, PCLK periods with HREF low between lines.
REQ-006 Parameter VFP_TICKS, default 16, PCLK periods after the last line before the frame ends.
REQ-007 CLK  input  1  sole clock; all logic on its rising edge.
REQ-008 RESET  input  1  reset, asynchronous, active-high.
REQ-009 ENABLE  input  1  level; high requests continuous frame generation.
REQ-010 PATTERN  input  2  pattern select: 0 colour bars, 1 solid, 2 checkerboard, 3 column ramp.
REQ-011 SOLID_COLOR  input  8  RGB332 colour used by pattern 1.
REQ-012 PCLK  output  1  emulated camera pixel clock, CLK/2.
REQ-013 HREF  output  1  high while line bytes are valid.
REQ-014 VSYNC  output  1  high during the frame sync interval.
REQ-015 DATA  output  8  camera byte, RGB565, two bytes per pixel.
REQ-016 BUSY  output  1  high from frame start to FRAME_DONE, inclusive.
REQ-017 FRAME_DONE  output  1  one-CLK pulse at the end of VFP.

Function
REQ-018 PCLK SHALL toggle on every CLK edge, free-running whenever RESET is low, independent of ENABLE.
REQ-019 HREF, VSYNC, DATA, BUSY and state SHALL update only on the CLK edge where PCLK goes 1->0 (a "tick"), so they are stable at every PCLK rising edge.
REQ-020 FSM states: IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP; one tick counter, a line counter (0..V_ACTIVE-1) and a byte counter (0..2*H_ACTIVE-1).
REQ-021 IDLE: outputs low; on a tick with ENABLE=1, enter VSYNC and latch PATTERN and SOLID_COLOR for the whole frame.
REQ-022 VSYNC: VSYNC=1 for VSYNC_TICKS ticks, then enter VBP.
REQ-023 VBP: all low for VBP_TICKS ticks, then enter ACTIVE with line=0.
REQ-024 ACTIVE: HREF=1 for exactly 2*H_ACTIVE ticks; an even byte index drives byte0, an odd byte index drives byte1 of pixel x = byte index / 2.
REQ-025 After ACTIVE: if line < V_ACTIVE-1, enter HBLANK for HBLANK_TICKS ticks, increment line, return to ACTIVE; otherwise enter VFP (no HBLANK after the last line).
REQ-026 VFP: all low for VFP_TICKS ticks, then pulse FRAME_DONE for one CLK; enter VSYNC if ENABLE=1 (new latch), else IDLE.
REQ-027 ENABLE deasserted mid-frame SHALL NOT truncate the frame; it only stops the next frame.
REQ-028 A PATTERN or SOLID_COLOR change mid-frame SHALL take effect only at the next frame start.
REQ-029 Pixel colour c (RGB332 r3,g3,b2) SHALL expand to R5={r,r[2:1]}, G6={g,g}, B5={b,b,b[1]}; byte0={R5,G6[5:3]}, byte1={G6[2:0],B5}.
REQ-030 Pattern 0: eight vertical bars of H_ACTIVE/8 pixels each: WHITE FF, YELLOW FC, LIGHTBLUE 0B, GREEN 1C, PURPLE E3, RED E0, BLUE 03, BLACK 00.
REQ-031 Pattern 2: 16x16 checkerboard; WHITE when (x[4] XOR line[4])=0, else BLACK.
REQ-032 Pattern 3: c = x[7:0].
REQ-033 DATA SHALL be 00 whenever HREF=0.
REQ-034 Default frame length: 8+16+144*352+143*32+16 ticks = 55304 ticks = 110608 CLK cycles, VSYNC rise to FRAME_DONE.

Reset
REQ-035 While RESET=1: PCLK=0, HREF=0, VSYNC=0, DATA=00, BUSY=0, FRAME_DONE=0, FSM=IDLE, all counters 0; an assertion mid-frame aborts the frame immediately.
REQ-036 After RESET falls, the first PCLK rise occurs on the first CLK edge and the first tick on the second.

Verification
REQ-037 Reset, ENABLE=1, PATTERN=1, SOLID_COLOR=E0 -> VSYNC high for 8 PCLK periods; each line carries 352 bytes alternating F8,00; 144 HREF pulses; one FRAME_DONE.
REQ-038 PATTERN=0 -> pixel 0 bytes FF,FF; pixel 22 bytes FF,E0; pixel 154 bytes 00,00; identical on every line.
REQ-039 PATTERN=2 -> line 0 pixels 0-15 bytes FF,FF, pixels 16-31 bytes 00,00; line 16 inverted.
REQ-040 ENABLE low during line 70 -> frame completes all 144 lines, FRAME_DONE pulses, FSM returns to IDLE, no further VSYNC.
REQ-041 PATTERN changed 0->1 during line 10 -> current frame remains bars; next frame is solid.
REQ-042 RESET pulsed during line 50 -> all outputs go to reset values asynchronously; next frame starts with a full VSYNC; a reference camera receiver captures a 176x144 image without address overrun.
